// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared types and constants for the MIPS-style core. Defines
//                the instruction word type, the IF/ID pipeline register
//                layout and the NOP/reset constants used by the fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_pkg;

    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    typedef logic [INSTR_W-1:0] instr_t;

    // IF/ID pipeline register contents.
    typedef struct packed {
        instr_t               instr;
        logic [INSTR_W-1:0]   pc4;
        logic                 valid;
    } if_id_t;

    // Bubble loaded on reset, flush and wrong-path squash.
    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.instr = NOP_INSTR;
        b.pc4   = '0;
        b.valid = 1'b0;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/if_id_register.sv
`default_nettype none
// ============================================================================
//  Module      : if_id_register
//  Description : IF/ID pipeline register. Holds the fetched instruction, its
//                PC+4 and a valid flag as one packed struct.
//  Ports       : clk   - rising-edge clock
//                reset - synchronous, active-high reset (loads a bubble)
//                stall - hold current contents
//                flush - load a bubble (wins over stall)
//                d     - next contents from the fetch stage
//                q     - registered contents
//  Revision    : 1.0  initial release
// ============================================================================
module if_id_register
    import cpu_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   stall,
    input  logic   flush,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= if_id_bubble();
        end else if (flush) begin
            r_q <= if_id_bubble();
        end else if (!stall) begin
            r_q <= d;
        end
    end

    assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : Fetch stage. Owns the program counter, drives the word
//                address of the asynchronous-read instruction memory, selects
//                the next PC (jump > branch > stall > sequential) and loads
//                the IF/ID register with the fetched word and PC+4.
//  Ports       : clk, reset           - clock, synchronous active-high reset
//                stall, flush         - hazard-unit controls
//                branch_taken/target  - branch redirect (byte address)
//                jump/jump_target     - jump redirect (byte address)
//                imem_addr            - word address to memory (combinational)
//                imem_rd              - word returned by memory, same cycle
//                pc                   - current PC (byte address)
//                if_id_instr/pc4/valid- IF/ID register outputs
//  Revision    : 1.0  initial release
// ============================================================================
module instruction_fetch_unit
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = 6,
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [DATA_W-1:0] branch_target,
    input  logic              jump,
    input  logic [DATA_W-1:0] jump_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_rd,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] if_id_instr,
    output logic [DATA_W-1:0] if_id_pc4,
    output logic              if_id_valid
);

    localparam logic [DATA_W-1:0] c_PC_STEP    = DATA_W'(4);
    // Targets are always word aligned; the low two bits are discarded.
    localparam logic [DATA_W-1:0] c_ALIGN_MASK = ~DATA_W'(3);

    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] w_pc4;
    logic [DATA_W-1:0] w_next_pc;
    logic              w_redirect;
    if_id_t            w_if_id_d;
    if_id_t            w_if_id_q;

    // Wraps modulo 2^DATA_W.
    assign w_pc4      = r_pc + c_PC_STEP;
    assign w_redirect = jump | branch_taken;

    // A redirect beats stall: the target is fetched next cycle regardless.
    always_comb begin
        w_next_pc = w_pc4;
        if (jump) begin
            w_next_pc = jump_target & c_ALIGN_MASK;
        end else if (branch_taken) begin
            w_next_pc = branch_target & c_ALIGN_MASK;
        end else if (stall) begin
            w_next_pc = r_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    // Word address wraps modulo 2^ADDR_W by simple truncation.
    assign imem_addr = r_pc[ADDR_W+1:2];
    assign pc        = r_pc;

    always_comb begin
        w_if_id_d       = if_id_bubble();
        w_if_id_d.instr = imem_rd;
        w_if_id_d.pc4   = w_pc4;
        w_if_id_d.valid = 1'b1;
    end

    // The word currently being fetched is on the wrong path when a redirect
    // is taken, so it is squashed together with an explicit flush.
    if_id_register u_if_id_register (
        .clk   (clk),
        .reset (reset),
        .stall (stall),
        .flush (flush | w_redirect),
        .d     (w_if_id_d),
        .q     (w_if_id_q)
    );

    assign if_id_instr = w_if_id_q.instr;
    assign if_id_pc4   = w_if_id_q.pc4;
    assign if_id_valid = w_if_id_q.valid;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_fetch_unit
//  Description : Scoreboard bench for instruction_fetch_unit. Each stimulus
//                cycle pushes the hand-computed post-edge state; a monitor
//                pops one entry per cycle and compares every output.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instruction_fetch_unit;

    typedef struct {
        int          id;
        logic [31:0] pc;
        logic [5:0]  addr;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic [5:0]  imem_addr;
    logic [31:0] imem_rd;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;

    logic [31:0] mem [0:63];
    exp_t        sb [$];
    int          tests;
    int          failed;
    int          step_id;

    instruction_fetch_unit #(
        .ADDR_W   (6),
        .DATA_W   (32),
        .RESET_PC (32'h0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .pc            (pc),
        .if_id_instr   (if_id_instr),
        .if_id_pc4     (if_id_pc4),
        .if_id_valid   (if_id_valid)
    );

    // Asynchronous-read instruction memory.
    assign imem_rd = mem[imem_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] m(input int i);
        return 32'hC0DE_0000 + 32'(i);
    endfunction

    task automatic chk(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge and record the state
    // expected right after the next rising edge.
    task automatic cyc(input logic r, input logic st, input logic fl,
                       input logic br, input logic [31:0] bt,
                       input logic jp, input logic [31:0] jt,
                       input logic [31:0] e_pc, input logic [5:0] e_addr,
                       input logic [31:0] e_instr, input logic [31:0] e_pc4,
                       input logic e_valid);
        exp_t e;
        @(negedge clk);
        reset         = r;
        stall         = st;
        flush         = fl;
        branch_taken  = br;
        branch_target = bt;
        jump          = jp;
        jump_target   = jt;
        step_id++;
        e.id    = step_id;
        e.pc    = e_pc;
        e.addr  = e_addr;
        e.instr = e_instr;
        e.pc4   = e_pc4;
        e.valid = e_valid;
        sb.push_back(e);
    endtask

    // Monitor: outputs are presented every cycle; compare after each edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc",        e.id, pc,                   e.pc);
                chk("imem_addr", e.id, {26'h0, imem_addr},   {26'h0, e.addr});
                chk("instr",     e.id, if_id_instr,          e.instr);
                chk("pc4",       e.id, if_id_pc4,            e.pc4);
                chk("valid",     e.id, {31'h0, if_id_valid}, {31'h0, e.valid});
            end
        end
    end

    initial begin
        int wait_cycles;
        tests   = 0;
        failed  = 0;
        step_id = 0;
        for (int i = 0; i < 64; i++) mem[i] = m(i);
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0;
        jump = 1'b0; jump_target = 32'h0;

        //     r  st fl br bt            jp jt            pc            addr instr  pc4           v
        // Reset and free-running fetch
        cyc(1, 0, 0, 0, 32'h0,       0, 32'h0,        32'h0,        0,  32'h0, 32'h0,        0);
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'h4,        1,  m(0),  32'h4,        1);
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'h8,        2,  m(1),  32'h8,        1);
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'hC,        3,  m(2),  32'hC,        1);
        // Stall two cycles at pc=C, then release
        cyc(0, 1, 0, 0, 32'h0,       0, 32'h0,        32'hC,        3,  m(2),  32'hC,        1);
        cyc(0, 1, 0, 0, 32'h0,       0, 32'h0,        32'hC,        3,  m(2),  32'hC,        1);
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'h10,       4,  m(3),  32'h10,       1);
        // Taken branch at pc=8
        cyc(1, 0, 0, 0, 32'h0,       0, 32'h0,        32'h0,        0,  32'h0, 32'h0,        0);
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'h4,        1,  m(0),  32'h4,        1);
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'h8,        2,  m(1),  32'h8,        1);
        cyc(0, 0, 0, 1, 32'h20,      0, 32'h0,        32'h20,       8,  32'h0, 32'h0,        0);
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'h24,       9,  m(8),  32'h24,       1);
        // Jump + branch + stall together: jump wins, redirect beats stall
        cyc(0, 1, 0, 1, 32'h80,      1, 32'h40,       32'h40,       16, 32'h0, 32'h0,        0);
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'h44,       17, m(16), 32'h44,       1);
        // Flush alone, then flush with stall (PC holds, bubble inserted)
        cyc(0, 0, 1, 0, 32'h0,       0, 32'h0,        32'h48,       18, 32'h0, 32'h0,        0);
        cyc(0, 1, 1, 0, 32'h0,       0, 32'h0,        32'h48,       18, 32'h0, 32'h0,        0);
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'h4C,       19, m(18), 32'h4C,       1);
        // Memory word-address wrap
        cyc(0, 0, 0, 0, 32'h0,       1, 32'hFC,       32'hFC,       63, 32'h0, 32'h0,        0);
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'h100,      0,  m(63), 32'h100,      1);
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'h104,      1,  m(0),  32'h104,      1);
        // 32-bit PC wrap
        cyc(0, 0, 0, 0, 32'h0,       1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 63, 32'h0, 32'h0,       0);
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'h0,        0,  m(63), 32'h0,        1);
        // Reset overrides stall and jump
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'h4,        1,  m(0),  32'h4,        1);
        cyc(1, 1, 0, 0, 32'h0,       1, 32'h40,       32'h0,        0,  32'h0, 32'h0,        0);
        // Misaligned targets are forced to word alignment
        cyc(0, 0, 0, 0, 32'h0,       1, 32'h23,       32'h20,       8,  32'h0, 32'h0,        0);
        cyc(0, 0, 0, 1, 32'h37,      0, 32'h0,        32'h34,       13, 32'h0, 32'h0,        0);
        cyc(0, 0, 0, 0, 32'h0,       0, 32'h0,        32'h38,       14, m(13), 32'h38,       1);

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(negedge clk);
        if (sb.size() > 0) begin
            tests++;
            failed++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
